// File: rtl/host_guest_mux.sv
// host_guest_mux -- N-channel transaction concentrator.
//
// Words from NUM_CH independent valid/ready sources are buffered in
// per-channel FIFOs. An arbiter chooses one eligible channel at a time and
// moves its head word into a registered valid/ready output. Each output word
// is tagged with the channel it came from.
//
// Ports:
//   clk         single clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   s_valid     per-channel input valid                   [NUM_CH]
//   s_ready     per-channel input ready                   [NUM_CH]
//   s_data      channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   flush       per-channel FIFO clear                    [NUM_CH]
//   m_valid     output word valid (registered)
//   m_ready     downstream ready
//   m_data      output payload (registered)
//   m_chan      source channel of m_data (registered)
//   fill_level  per-channel occupancy, channel i at [i*LW +: LW]
module host_guest_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 8,
  parameter int ARB_MODE   = 0,
  parameter int CW         = $clog2(NUM_CH),
  parameter int LW         = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            s_valid,
  output logic [NUM_CH-1:0]            s_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_CH-1:0]            flush,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [CW-1:0]                m_chan,
  output logic [NUM_CH*LW-1:0]         fill_level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem    [NUM_CH][DEPTH];
  logic [LW-1:0]         count  [NUM_CH];
  logic [AW-1:0]         wr_ptr [NUM_CH];
  logic [AW-1:0]         rd_ptr [NUM_CH];
  logic [CW-1:0]         rr_ptr;

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] eligible;
  logic              grant_valid;
  logic [CW-1:0]     grant_idx;
  logic              out_free;

  // Channel examined at scan step k. Round-robin starts just after the last
  // granted channel and wraps; fixed priority always starts at channel 0.
  function automatic logic [CW-1:0] scan_index(input int k, input logic [CW-1:0] ptr);
    int idx;
    idx = (ARB_MODE == 0) ? (int'(ptr) + 1 + k) % NUM_CH : k;
    return CW'(idx);
  endfunction

  // Per-channel handshake and status. s_ready depends only on rst and the
  // registered count, never on m_ready or a pop, so a full FIFO cannot accept
  // in the cycle it is popped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    s_ready    = '0;
    push       = '0;
    eligible   = '0;
    fill_level = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s_ready[i]              = ~rst & (count[i] < LW'(DEPTH));
      push[i]                 = s_valid[i] & s_ready[i];
      eligible[i]             = (count[i] != '0) & ~flush[i];
      fill_level[i*LW +: LW]  = count[i];
    end
  end

  // Arbiter: first eligible channel in scan order.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!grant_valid && eligible[scan_index(k, rr_ptr)]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_index(k, rr_ptr);
      end
    end
  end

  // The output register takes a new word when empty or being drained.
  assign out_free = ~m_valid | m_ready;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i] = out_free & grant_valid & (grant_idx == CW'(i));
    end
  end

  // FIFO counters and pointers. Flush wins over a same-cycle write or pop.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (flush[i]) begin
          count[i]  <= '0;
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end else begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
          case ({push[i], pop[i]})
            2'b10:   count[i] <= count[i] + LW'(1);
            2'b01:   count[i] <= count[i] - LW'(1);
            default: count[i] <= count[i];
          endcase
        end
      end
    end
  end

  // NOTE: the storage array has no reset; contents are only visible through
  // the counters and pointers, which are reset, so clearing it would only
  // cost flops.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= s_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output register and round-robin pointer. Data and tag only change on a
  // grant, so they are held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      rr_ptr  <= CW'(NUM_CH - 1);
    end else if (out_free) begin
      m_valid <= grant_valid;
      if (grant_valid) begin
        m_data <= mem[grant_idx][rd_ptr[grant_idx]];
        m_chan <= grant_idx;
        if (ARB_MODE == 0) rr_ptr <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_host_guest_mux.sv
// Testbench for host_guest_mux: one round-robin and one fixed-priority
// instance share the same stimulus. A queue-based reference model of each is
// stepped at every clock edge and compared against both instances.
module tb_host_guest_mux;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   s_valid;
  logic [3:0]   flush;
  logic [127:0] s_data;
  logic         m_ready;

  logic [3:0]   s_ready    [2];
  logic         m_valid    [2];
  logic [31:0]  m_data     [2];
  logic [1:0]   m_chan     [2];
  logic [15:0]  fill_level [2];

  always #5 clk = ~clk;

  host_guest_mux #(.DATA_WIDTH(32), .NUM_CH(4), .DEPTH(8), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready[0]), .s_data(s_data),
    .flush(flush), .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
    .m_chan(m_chan[0]), .fill_level(fill_level[0])
  );

  host_guest_mux #(.DATA_WIDTH(32), .NUM_CH(4), .DEPTH(8), .ARB_MODE(1)) dut_pri (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready[1]), .s_data(s_data),
    .flush(flush), .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
    .m_chan(m_chan[1]), .fill_level(fill_level[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (index m: 0 = round-robin, 1 = priority)
  logic [31:0] mq [8][$];   // queue of channel c for model m at m*4+c
  logic        mv [2];
  logic [31:0] md [2];
  int          mc [2];
  int          mptr [2];

  task automatic model_step(input int m);
    bit acc [4];
    bit found;
    int g;
    int c;
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[m*4+i].delete();
      mv[m] = 1'b0; md[m] = '0; mc[m] = 0; mptr[m] = 3;
      return;
    end
    for (int i = 0; i < 4; i++) acc[i] = s_valid[i] && (mq[m*4+i].size() < 8);
    found = 1'b0; g = 0;
    for (int k = 0; k < 4; k++) begin
      c = (m == 0) ? (mptr[m] + 1 + k) % 4 : k;
      if (!found && mq[m*4+c].size() > 0 && !flush[c]) begin
        found = 1'b1; g = c;
      end
    end
    if (!mv[m] || m_ready) begin
      if (found) begin
        mv[m] = 1'b1;
        md[m] = mq[m*4+g].pop_front();
        mc[m] = g;
        if (m == 0) mptr[m] = g;
      end else begin
        mv[m] = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (flush[i]) mq[m*4+i].delete();
      else if (acc[i]) mq[m*4+i].push_back(s_data[i*32 +: 32]);
    end
  endtask

  task automatic compare_all();
    logic [3:0]  er;
    logic [15:0] ef;
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 4; c++) begin
        er[c]         = !rst && (mq[m*4+c].size() < 8);
        ef[c*4 +: 4]  = 4'(mq[m*4+c].size());
      end
      check($sformatf("dut%0d s_ready", m),    32'(s_ready[m]),    32'(er));
      check($sformatf("dut%0d fill_level", m), 32'(fill_level[m]), 32'(ef));
      check($sformatf("dut%0d m_valid", m),    32'(m_valid[m]),    32'(mv[m]));
      check($sformatf("dut%0d m_data", m),     m_data[m],          md[m]);
      check($sformatf("dut%0d m_chan", m),     32'(m_chan[m]),     32'(mc[m]));
    end
  endtask

  // One clock edge: step the model with the inputs the DUT samples, then
  // compare just after the edge. Inputs are changed only after this returns.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    s_valid = '0; flush = '0; s_data = '0; m_ready = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic        rst;
    logic [3:0]  sv;
    logic [31:0] d;
    logic        mr;
    logic        exp_mv;
    logic [1:0]  exp_ch;
    logic [31:0] exp_md;
    logic [15:0] exp_fill;
    logic [3:0]  exp_sr;
  } vec_t;

  vec_t vecs [7];

  int exp_rr  [8];
  int exp_pri [8];

  initial begin
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; md[m] = '0; mc[m] = 0; mptr[m] = 3;
    end
    idle_inputs();
    rst = 1'b1;

    // Reset held 3 cycles with all s_valid high, then release, then a single
    // word on ch2 that must emerge one edge after it is written.
    vecs[0] = '{1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd0, 32'h0,         16'h0000, 4'h0};
    vecs[1] = '{1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd0, 32'h0,         16'h0000, 4'h0};
    vecs[2] = '{1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd0, 32'h0,         16'h0000, 4'h0};
    vecs[3] = '{1'b0, 4'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd0, 32'h0,         16'h0000, 4'hF};
    vecs[4] = '{1'b0, 4'h4, 32'hA5A5_0001, 1'b1, 1'b0, 2'd0, 32'h0,         16'h0100, 4'hF};
    vecs[5] = '{1'b0, 4'h0, 32'hA5A5_0001, 1'b1, 1'b1, 2'd2, 32'hA5A5_0001, 16'h0000, 4'hF};
    vecs[6] = '{1'b0, 4'h0, 32'h0,         1'b1, 1'b0, 2'd2, 32'hA5A5_0001, 16'h0000, 4'hF};

    for (int v = 0; v < 7; v++) begin
      rst     = vecs[v].rst;
      s_valid = vecs[v].sv;
      s_data  = {4{vecs[v].d}};
      m_ready = vecs[v].mr;
      flush   = '0;
      tick();
      for (int m = 0; m < 2; m++) begin
        check($sformatf("vec%0d dut%0d m_valid", v, m), 32'(m_valid[m]),    32'(vecs[v].exp_mv));
        check($sformatf("vec%0d dut%0d m_chan", v, m),  32'(m_chan[m]),     32'(vecs[v].exp_ch));
        check($sformatf("vec%0d dut%0d m_data", v, m),  m_data[m],          vecs[v].exp_md);
        check($sformatf("vec%0d dut%0d fill", v, m),    32'(fill_level[m]), 32'(vecs[v].exp_fill));
        check($sformatf("vec%0d dut%0d s_ready", v, m), 32'(s_ready[m]),    32'(vecs[v].exp_sr));
      end
    end

    // ---- arbitration order: 2 words preloaded on every channel
    exp_rr  = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_pri = '{0, 0, 1, 1, 2, 2, 3, 3};
    reset_dut();
    for (int w = 0; w < 2; w++) begin
      s_valid = 4'hF;
      for (int c = 0; c < 4; c++) s_data[c*32 +: 32] = 32'h0A00_0000 + 32'(c*16 + w);
      tick();
    end
    s_valid = '0;
    m_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      check($sformatf("rr seq%0d valid", n),  32'(m_valid[0]), 1);
      check($sformatf("rr seq%0d chan", n),   32'(m_chan[0]),  32'(exp_rr[n]));
      check($sformatf("pri seq%0d valid", n), 32'(m_valid[1]), 1);
      check($sformatf("pri seq%0d chan", n),  32'(m_chan[1]),  32'(exp_pri[n]));
      tick();
    end
    check("arb drained rr", 32'(m_valid[0]), 0);

    // ---- full FIFO and backpressure on ch1
    reset_dut();
    for (int w = 0; w < 9; w++) begin
      s_valid = 4'b0010;
      s_data[63:32] = 32'hF000_0000 + 32'(w);
      tick();
    end
    s_data[63:32] = 32'hF000_0009;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("full dut%0d s_ready1", m), 32'(s_ready[m][1]),      0);
      check($sformatf("full dut%0d fill1", m),    32'(fill_level[m][7:4]), 8);
    end
    tick();
    s_valid = '0;
    for (int n = 0; n < 20; n++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        check($sformatf("stall%0d dut%0d m_data", n, m), m_data[m], 32'hF000_0000);
        check($sformatf("stall%0d dut%0d fill1", n, m),  32'(fill_level[m][7:4]), 8);
      end
    end
    m_ready = 1'b1;
    for (int n = 0; n < 11; n++) tick();
    check("full drained", 32'(m_valid[0]), 0);

    // ---- flush colliding with a write and a drain on ch3
    reset_dut();
    for (int w = 0; w < 6; w++) begin
      s_valid = 4'b1000;
      s_data[127:96] = 32'h3300_0000 + 32'(w);
      tick();
    end
    for (int m = 0; m < 2; m++) begin
      check($sformatf("pre-flush dut%0d fill3", m), 32'(fill_level[m][15:12]), 5);
      check($sformatf("pre-flush dut%0d m_data", m), m_data[m], 32'h3300_0000);
      check($sformatf("pre-flush dut%0d m_chan", m), 32'(m_chan[m]), 3);
    end
    flush = 4'b1000;
    s_data[127:96] = 32'h3300_00FF;
    m_ready = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("flush dut%0d fill3", m),   32'(fill_level[m][15:12]), 0);
      check($sformatf("flush dut%0d m_valid", m), 32'(m_valid[m]), 0);
    end
    flush = '0;
    s_valid = '0;
    tick();
    check("post-flush m_valid", 32'(m_valid[0]), 0);

    // ---- randomized traffic against the model
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      s_valid = 4'($urandom);
      for (int c = 0; c < 4; c++) s_data[c*32 +: 32] = $urandom;
      m_ready = (n % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      rst     = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/host_guest_mux.md
Name: host_guest_mux

Overview:
Parametrised N-channel transaction concentrator. It buffers words from NUM_CH independent valid/ready sources in per-channel FIFOs and arbitrates them onto one registered valid/ready output, tagging each word with its source channel. It is the RTL-side counterpart of the testbench host/guest channel, generalised in width, depth, channel count and arbitration mode. Typical use is to merge multiple producer streams into a single consumer or scoreboard tap.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
NUM_CH, 4, number of input channels (2..16)
DEPTH, 8, per-channel FIFO depth in words (power of 2, >=2)
ARB_MODE, 0, 0 = round-robin; 1 = fixed priority, lowest index wins
CW, $clog2(NUM_CH), derived; width of channel tag
LW, $clog2(DEPTH)+1, derived; width of fill level

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
s_valid  in  NUM_CH  per-channel input valid
s_ready  out  NUM_CH  per-channel input ready
s_data  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
flush  in  NUM_CH  per-channel FIFO clear, sampled at the clock edge
m_valid  out  1  output word valid (registered)
m_ready  in  1  downstream ready
m_data  out  DATA_WIDTH  output payload (registered)
m_chan  out  CW  source channel of m_data (registered)
fill_level  out  NUM_CH*LW  per-channel occupancy, 0..DEPTH

Behaviour:
- Reset (rst high at an edge): all FIFO counts and pointers go to 0. m_valid=0, m_data=0, m_chan=0, fill_level=0. The round-robin pointer is set to NUM_CH-1, so channel 0 has first grant. s_ready is forced to 0 while rst is high.
- Reset mid-operation discards all buffered words and the output register. No partial state survives.
- Write: channel i accepts a word when s_valid[i] & s_ready[i] at an edge.
- s_ready[i] = ~rst & (count[i] < DEPTH). It has no combinational dependence on m_ready or pops.
- A full FIFO never accepts in the same cycle as a pop from it; there is no pass-through.
- Output register loads when (!m_valid | m_ready) and at least one eligible channel is non-empty. The granted FIFO pops in that same edge.
- If no channel is eligible while m_ready drains the register, m_valid drops to 0.
- Hold rule: while m_valid & !m_ready, m_data and m_chan are stable and no pop occurs.
- Latency: a word written at edge k into an empty system appears on m_valid after edge k+1. There is no bypass from s_data to m_data.
- Throughput: 1 word/cycle sustained while m_ready=1 and any FIFO is non-empty.
- Eligibility: count[i] > 0 and flush[i] = 0.
- ARB_MODE=0: grant the first eligible channel searching from (ptr+1) mod NUM_CH upward with wrap. ptr is updated to the granted index only on a grant.
- ARB_MODE=1: grant the lowest eligible index. ptr is unused.
- Flush: flush[i] at an edge sets count[i] and pointers to 0. It overrides a simultaneous write and pop on channel i. A word of channel i already in the output register is unaffected.
- Count update per edge: +1 on write, -1 on pop, unchanged on both or neither, 0 on flush.
- fill_level[i] shows the count after the most recent edge.
- Boundaries: full and pop in the same cycle gives count DEPTH-1 and s_ready high next cycle. Empty and write with the output idle: the word is not granted until the following edge. Pointer wrap uses modulo DEPTH (power of 2, natural wrap).

Test Plan:
- Reset: drive rst=1 for 3 cycles with s_valid=4'hF -> s_ready=0, m_valid=0, fill_level all 0, m_chan=0. After release, s_ready=4'hF next cycle.
- Latency/single: write 32'hA5A5_0001 on ch2 at edge k, m_ready=1 -> m_valid=1, m_data=32'hA5A5_0001, m_chan=2 after edge k+1, held 1 cycle, then m_valid=0.
- Round-robin (ARB_MODE=0): preload 2 words on each of ch0..ch3, then set m_ready=1 -> m_chan sequence 0,1,2,3,0,1,2,3 on consecutive cycles.
- Priority (ARB_MODE=1) with the same preload -> m_chan sequence 0,0,1,1,2,2,3,3.
- Full/backpressure: m_ready=0, write 9 words on ch1 (DEPTH=8) -> one word in the output register and 8 in the FIFO. s_ready[1]=0, fill_level[1]=8. The extra word is not accepted, and m_data stays stable for 20 stalled cycles.
- Flush collision: ch3 holds 5 words; in one cycle assert flush[3], s_valid[3] and m_ready=1 -> fill_level[3]=0 next cycle, no ch3 grant that cycle, and the register word already shown is delivered intact.
